// File: rtl/alu_uart_if.sv
// Sequencer between a UART and an ALU: collects operand A, operand B and opcode bytes,
// then transmits the ALU result byte followed by a flags byte {carry, zero}.
module alu_uart_if #(
    parameter int unsigned NB_DATA  = 8,
    parameter int unsigned NB_STATE = 3
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NB_DATA-1:0]  i_rx_data,
    input  logic                i_rx_done,
    input  logic [NB_DATA-1:0]  i_alu_result,
    input  logic                i_alu_carry,
    input  logic                i_alu_zero,
    input  logic                i_tx_busy,
    output logic [NB_DATA-1:0]  o_alu_data,
    output logic                o_enable_1,
    output logic                o_enable_2,
    output logic                o_enable_3,
    output logic [NB_DATA-1:0]  o_tx_data,
    output logic                o_tx_start,
    output logic                o_rx_overrun,
    output logic [NB_STATE-1:0] o_state
);

    localparam logic [NB_STATE-1:0] StWaitA   = NB_STATE'(0);
    localparam logic [NB_STATE-1:0] StWaitB   = NB_STATE'(1);
    localparam logic [NB_STATE-1:0] StWaitOp  = NB_STATE'(2);
    localparam logic [NB_STATE-1:0] StExec    = NB_STATE'(3);
    localparam logic [NB_STATE-1:0] StCapture = NB_STATE'(4);
    localparam logic [NB_STATE-1:0] StSendRes = NB_STATE'(5);
    localparam logic [NB_STATE-1:0] StSendFlg = NB_STATE'(6);
    localparam logic [NB_STATE-1:0] StWaitTx  = NB_STATE'(7);

    logic [NB_STATE-1:0] state_q, state_d;
    logic [NB_DATA-1:0]  alu_data_q, alu_data_d;
    logic                en1_q, en1_d, en2_q, en2_d, en3_q, en3_d;
    logic [NB_DATA-1:0]  tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                overrun_q, overrun_d;
    logic [NB_DATA-1:0]  res_q, res_d;
    logic                carry_q, carry_d, zero_q, zero_d;
    logic                sent_res_q, sent_res_d;
    logic                accepting;

    assign accepting = (state_q == StWaitA) || (state_q == StWaitB) || (state_q == StWaitOp);

    always_comb begin
        state_d    = state_q;
        alu_data_d = alu_data_q;
        en1_d      = 1'b0;
        en2_d      = 1'b0;
        en3_d      = 1'b0;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        overrun_d  = overrun_q | (i_rx_done & ~accepting);
        res_d      = res_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        sent_res_d = sent_res_q;

        case (state_q)
            StWaitA: if (i_rx_done) begin
                alu_data_d = i_rx_data;
                en1_d      = 1'b1;
                state_d    = StWaitB;
            end
            StWaitB: if (i_rx_done) begin
                alu_data_d = i_rx_data;
                en2_d      = 1'b1;
                state_d    = StWaitOp;
            end
            StWaitOp: if (i_rx_done) begin
                alu_data_d = i_rx_data;
                en3_d      = 1'b1;
                state_d    = StExec;
            end
            StExec: state_d = StCapture;
            StCapture: begin
                res_d   = i_alu_result;
                carry_d = i_alu_carry;
                zero_d  = i_alu_zero;
                state_d = StSendRes;
            end
            StSendRes: if (!i_tx_busy) begin
                tx_data_d  = res_q;
                tx_start_d = 1'b1;
                sent_res_d = 1'b1;
                state_d    = StWaitTx;
            end
            StSendFlg: if (!i_tx_busy) begin
                tx_data_d  = {{(NB_DATA-2){1'b0}}, carry_q, zero_q};
                tx_start_d = 1'b1;
                sent_res_d = 1'b0;
                state_d    = StWaitTx;
            end
            StWaitTx: begin
                // Start pulse marks the first cycle, before the transmitter can report busy.
                if (!tx_start_q && !i_tx_busy) begin
                    state_d = sent_res_q ? StSendFlg : StWaitA;
                end
            end
            default: state_d = StWaitA;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= StWaitA;
            alu_data_q <= '0;
            en1_q      <= 1'b0;
            en2_q      <= 1'b0;
            en3_q      <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            overrun_q  <= 1'b0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            sent_res_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_data_q <= alu_data_d;
            en1_q      <= en1_d;
            en2_q      <= en2_d;
            en3_q      <= en3_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            overrun_q  <= overrun_d;
            res_q      <= res_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            sent_res_q <= sent_res_d;
        end
    end

    assign o_state      = state_q;
    assign o_alu_data   = alu_data_q;
    assign o_enable_1   = en1_q;
    assign o_enable_2   = en2_q;
    assign o_enable_3   = en3_q;
    assign o_tx_data    = tx_data_q;
    assign o_tx_start   = tx_start_q;
    assign o_rx_overrun = overrun_q;

endmodule

// File: tb/tb_alu_uart_if.sv
// Bench for alu_uart_if: transaction-level model checked every cycle, plus directed
// scenarios with hand-computed byte sequences.
module tb_alu_uart_if;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic [7:0] alu_res = 8'h00;
    logic       alu_cy = 1'b0;
    logic       alu_zr = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] o_alu_data;
    logic       o_en1, o_en2, o_en3;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_ovr;
    logic [2:0] o_state;

    alu_uart_if #(.NB_DATA(8), .NB_STATE(3)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_alu_result (alu_res),
        .i_alu_carry  (alu_cy),
        .i_alu_zero   (alu_zr),
        .i_tx_busy    (tx_busy),
        .o_alu_data   (o_alu_data),
        .o_enable_1   (o_en1),
        .o_enable_2   (o_en2),
        .o_enable_3   (o_en3),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .o_rx_overrun (o_ovr),
        .o_state      (o_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] tx_log[$];
    int         en_k[$];
    logic [7:0] en_d[$];
    int         en_c[$];

    // Model: bytes collected so far, post-opcode progress, and a queue of bytes to send.
    int         m_got;
    int         m_cd;
    logic [7:0] m_q[$];
    bit         m_in_tx;
    bit         m_first;
    logic [7:0] m_alu;
    logic [2:0] m_en;
    logic [7:0] m_tx;
    bit         m_start;
    bit         m_ovr;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_got = 0; m_cd = 0; m_q.delete(); m_in_tx = 0; m_first = 0;
        m_alu = 8'h00; m_en = 3'b000; m_tx = 8'h00; m_start = 0; m_ovr = 0;
    endtask

    task automatic model_step(input logic rxd, input logic [7:0] rxb, input logic busy,
                              input logic [7:0] res, input logic cy, input logic zr);
        bit full;
        full    = (m_got == 3);
        m_en    = 3'b000;
        m_start = 0;
        if (rxd) begin
            if (!full) begin
                m_en[m_got] = 1'b1;
                m_alu = rxb;
                m_got++;
                if (m_got == 3) m_cd = 0;
            end else begin
                m_ovr = 1;
            end
        end
        if (full) begin
            if (m_cd == 0) begin
                m_cd = 1;
            end else if (m_cd == 1) begin
                m_q.delete();
                m_q.push_back(res);
                m_q.push_back({6'b0, cy, zr});
                m_cd = 2;
            end else if (!m_in_tx) begin
                if (!busy) begin
                    m_tx = m_q.pop_front();
                    m_start = 1; m_in_tx = 1; m_first = 1;
                end
            end else if (m_first) begin
                m_first = 0;
            end else if (!busy) begin
                m_in_tx = 0;
                if (m_q.size() == 0) m_got = 0;
            end
        end
    endtask

    function automatic logic [2:0] model_state();
        if (m_got < 3) return 3'(m_got);
        if (m_cd == 0) return 3'd3;
        if (m_cd == 1) return 3'd4;
        if (m_in_tx)   return 3'd7;
        return (m_q.size() == 2) ? 3'd5 : 3'd6;
    endfunction

    // Per-cycle comparison against the model, plus event logging.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step(rx_done, rx_data, tx_busy, alu_res, alu_cy, alu_zr);
            #1;
            cyc++;
            check("state", o_state, model_state());
            check("alu_data", o_alu_data, m_alu);
            check("enables", {o_en3, o_en2, o_en1}, m_en);
            check("tx_data", o_tx_data, m_tx);
            check("tx_start", o_tx_start, m_start);
            check("overrun", o_ovr, m_ovr);
            check("one_hot_enable", ($countones({o_en3, o_en2, o_en1}) <= 1), 1);
            check("start_while_busy", (o_tx_start && tx_busy), 0);
            if (o_tx_start) tx_log.push_back(o_tx_data);
            if (o_en1) begin en_k.push_back(1); en_d.push_back(o_alu_data); en_c.push_back(cyc); end
            if (o_en2) begin en_k.push_back(2); en_d.push_back(o_alu_data); en_c.push_back(cyc); end
            if (o_en3) begin en_k.push_back(3); en_d.push_back(o_alu_data); en_c.push_back(cyc); end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); rx_done = 1'b1; rx_data = b;
        @(negedge clk); rx_done = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send_byte(a); send_byte(b); send_byte(op);
    endtask

    task automatic wait_state(input logic [2:0] st, input int max, input string nm);
        bit found;
        found = 0;
        for (int i = 0; i < max && !found; i++) begin
            @(negedge clk);
            if (o_state == st) found = 1;
        end
        if (!found) begin
            n_tests++; n_fail++;
            $display("FAIL %s: timeout, state %0d, required %0d", nm, o_state, st);
        end
    endtask

    task automatic check_tx_pair(input string nm, input int base, input logic [7:0] r,
                                 input logic [7:0] f);
        check({nm, "_count"}, tx_log.size() - base, 2);
        if (tx_log.size() >= base + 2) begin
            check({nm, "_res"}, tx_log[base], r);
            check({nm, "_flg"}, tx_log[base+1], f);
        end
    endtask

    task automatic check_en(input string nm, input int idx, input int k, input logic [7:0] d);
        if (en_k.size() > idx) begin
            check({nm, "_k"}, en_k[idx], k);
            check({nm, "_d"}, en_d[idx], d);
        end else begin
            check({nm, "_present"}, en_k.size(), idx + 1);
        end
    endtask

    initial begin
        int tb;
        int eb;
        #1 rst_n = 1'b0;
        #1;
        check("rst_state", o_state, 0);
        check("rst_outputs", {o_alu_data, o_en1, o_en2, o_en3, o_tx_data, o_tx_start, o_ovr}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic transaction: 5 op 3 -> result 0x08, flags 0x00.
        alu_res = 8'h08; alu_cy = 1'b0; alu_zr = 1'b0;
        tb = tx_log.size(); eb = en_k.size();
        send_seq(8'h05, 8'h03, 8'h20);
        wait_state(3'd0, 40, "basic_done");
        check_en("basic_en1", eb, 1, 8'h05);
        check_en("basic_en2", eb + 1, 2, 8'h03);
        check_en("basic_en3", eb + 2, 3, 8'h20);
        check_tx_pair("basic_tx", tb, 8'h08, 8'h00);

        // Carry and zero both set -> flags byte 0x03.
        alu_res = 8'h00; alu_cy = 1'b1; alu_zr = 1'b1;
        tb = tx_log.size();
        send_seq(8'hFF, 8'h01, 8'h20);
        wait_state(3'd0, 40, "flags_done");
        check_tx_pair("flags_tx", tb, 8'h00, 8'h03);

        // Back-to-back bytes, including 0xFF and 0x00 values.
        alu_res = 8'hFE; alu_cy = 1'b0; alu_zr = 1'b0;
        tb = tx_log.size(); eb = en_k.size();
        @(negedge clk); rx_done = 1'b1; rx_data = 8'hFF;
        @(negedge clk); rx_data = 8'h00;
        @(negedge clk); rx_data = 8'h00;
        @(negedge clk); rx_done = 1'b0;
        wait_state(3'd0, 40, "burst_done");
        check_en("burst_en1", eb, 1, 8'hFF);
        check_en("burst_en2", eb + 1, 2, 8'h00);
        check_en("burst_en3", eb + 2, 3, 8'h00);
        if (en_c.size() >= eb + 3) begin
            check("burst_consec_12", en_c[eb+1] - en_c[eb], 1);
            check("burst_consec_23", en_c[eb+2] - en_c[eb+1], 1);
        end
        check_tx_pair("burst_tx", tb, 8'hFE, 8'h00);

        // Transmitter busy for 20 cycles at the result send.
        alu_res = 8'h5A; alu_cy = 1'b0; alu_zr = 1'b1;
        tx_busy = 1'b1;
        tb = tx_log.size();
        send_seq(8'h10, 8'h20, 8'h30);
        wait_state(3'd5, 20, "busy_reach_send");
        repeat (20) @(negedge clk);
        check("busy_no_start", tx_log.size() - tb, 0);
        tx_busy = 1'b0;
        @(negedge clk);
        check("busy_start_after_fall", o_tx_start, 1);
        @(negedge clk); tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        check("busy_hold_wait_tx", o_state, 7);
        tx_busy = 1'b0;
        wait_state(3'd0, 40, "busy_done");
        check_tx_pair("busy_tx", tb, 8'h5A, 8'h01);

        // Byte arriving during WAIT_TX is dropped and flagged.
        alu_res = 8'h11; alu_cy = 1'b1; alu_zr = 1'b0;
        tb = tx_log.size();
        send_seq(8'h01, 8'h02, 8'h03);
        wait_state(3'd7, 40, "ovr_reach_wait_tx");
        eb = en_k.size();
        rx_done = 1'b1; rx_data = 8'hAA;
        @(negedge clk); rx_done = 1'b0;
        check("ovr_flag", o_ovr, 1);
        wait_state(3'd0, 40, "ovr_done");
        check("ovr_no_enable", en_k.size() - eb, 0);
        check_tx_pair("ovr_tx", tb, 8'h11, 8'h02);
        alu_res = 8'h22; alu_cy = 1'b0; alu_zr = 1'b0;
        tb = tx_log.size();
        send_seq(8'h04, 8'h05, 8'h06);
        wait_state(3'd0, 40, "ovr_next_done");
        check_tx_pair("ovr_next_tx", tb, 8'h22, 8'h00);
        check("ovr_sticky", o_ovr, 1);

        // Reset in WAIT_OP: outputs clear at once, next byte is operand A.
        send_byte(8'h41); send_byte(8'h42);
        check("rst_mid_pre_state", o_state, 2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_state", o_state, 0);
        check("rst_mid_alu_data", o_alu_data, 0);
        check("rst_mid_ovr", o_ovr, 0);
        check("rst_mid_strobes", {o_en1, o_en2, o_en3, o_tx_start, o_tx_data}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; rx_done = 1'b1; rx_data = 8'h77;
        @(negedge clk); rx_done = 1'b0;
        check("rst_rel_en1", {o_en3, o_en2, o_en1}, 3'b001);
        check("rst_rel_data", o_alu_data, 8'h77);
        send_byte(8'h01); send_byte(8'h02);
        wait_state(3'd7, 40, "rst_tx_reach_wait_tx");
        rst_n = 1'b0;
        #1;
        check("rst_tx_state", o_state, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_stays_idle", o_state, 0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_uart_if.md
ALU_UART_IF -- requirements
Module: alu_uart_if

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 8, giving the width of operand, opcode, result and UART bytes.
REQ-002 The block SHALL have parameter NB_STATE, default 3, giving the width of o_state.
REQ-003 i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 i_reset  input  1  asynchronous, active-low reset.
REQ-005 i_rx_data  input  NB_DATA  byte from the UART receiver, valid while i_rx_done=1.
REQ-006 i_rx_done  input  1  one-cycle pulse marking a received byte.
REQ-007 i_alu_result  input  NB_DATA  ALU result.
REQ-008 i_alu_carry  input  1  ALU carry flag.
REQ-009 i_alu_zero  input  1  ALU zero flag.
REQ-010 i_tx_busy  input  1  UART transmitter busy.
REQ-011 o_alu_data  output  NB_DATA  byte driven to the ALU data input.
REQ-012 o_enable_1 / o_enable_2 / o_enable_3  output  1 each  one-cycle latch strobes for operand A, operand B and opcode.
REQ-013 o_tx_data  output  NB_DATA  byte to transmit, held stable from the o_tx_start cycle until the next load.
REQ-014 o_tx_start  output  1  one-cycle transmit request.
REQ-015 o_rx_overrun  output  1  sticky flag for a byte received while not accepting.
REQ-016 o_state  output  NB_STATE  current FSM state code, for LEDs.

Function
REQ-017 The FSM SHALL have the states WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, CAPTURE=4, SEND_RES=5, SEND_FLG=6, WAIT_TX=7, and o_state SHALL equal the current state code.
REQ-018 In WAIT_A, WAIT_B and WAIT_OP, a cycle with i_rx_done=1 SHALL register i_rx_data onto o_alu_data, pulse o_enable_1, o_enable_2 or o_enable_3 respectively in the next cycle only, and advance to WAIT_B, WAIT_OP or EXEC respectively.
REQ-019 All outputs SHALL be registered; o_alu_data SHALL hold its last value when no strobe is active.
REQ-020 At most one of o_enable_1..3 SHALL be high in any cycle.
REQ-021 EXEC SHALL last exactly one cycle; this is the cycle in which o_enable_3 is high.
REQ-022 CAPTURE SHALL last exactly one cycle and SHALL register i_alu_result, i_alu_carry and i_alu_zero. If the opcode byte arrives at cycle N, the capture is at the end of cycle N+2.
REQ-023 In SEND_RES, when i_tx_busy=0, the block SHALL load o_tx_data with the captured result, pulse o_tx_start for one cycle and go to WAIT_TX; when i_tx_busy=1 it SHALL stay in SEND_RES.
REQ-024 In SEND_FLG, the block SHALL behave as in SEND_RES but with o_tx_data = {zeros[NB_DATA-1:2], carry, zero}.
REQ-025 WAIT_TX SHALL ignore i_tx_busy in its first cycle, then wait until i_tx_busy=0. It SHALL then go to SEND_FLG if the result byte was the one sent, otherwise to WAIT_A.
REQ-026 o_tx_start SHALL never be asserted while i_tx_busy=1.
REQ-027 i_rx_done=1 in EXEC, CAPTURE, SEND_RES, SEND_FLG or WAIT_TX SHALL discard the byte and set o_rx_overrun=1, which stays set until reset.
REQ-028 A byte of any value, including 0x00 and 0xFF, SHALL be accepted without special treatment.
REQ-029 Back-to-back i_rx_done pulses on consecutive cycles in the receiving states SHALL each be accepted, one per state.

Reset
REQ-030 While i_reset=0, regardless of clock, the block SHALL be in state WAIT_A and SHALL drive o_alu_data=0, o_enable_1..3=0, o_tx_data=0, o_tx_start=0, o_rx_overrun=0 and o_state=0.
REQ-031 Reset asserted mid-sequence, including during WAIT_TX, SHALL abandon the sequence; after release the block SHALL wait for a fresh operand A.
REQ-032 The first rising edge after reset release SHALL already be able to accept a byte.

Verification
REQ-033 Bytes 0x05, 0x03, 0x20 with a stub ALU returning result 0x08, carry 0, zero 0 and i_tx_busy=0 -> o_enable_1 with o_alu_data=0x05, o_enable_2 with 0x03, o_enable_3 with 0x20; then o_tx_start with 0x08, then o_tx_start with 0x00; o_state returns to 0.
REQ-034 Stub result 0x00, carry 1, zero 1 -> second transmitted byte is 0x03.
REQ-035 i_tx_busy held at 1 for 20 cycles at SEND_RES -> no o_tx_start during those cycles; one pulse on the cycle after busy falls.
REQ-036 A byte 0xAA pulsed during WAIT_TX -> o_rx_overrun=1, no enable strobe, and the next sequence still completes correctly.
REQ-037 i_reset=0 asserted in WAIT_OP after A and B -> all outputs go to 0 at once; after release, the next byte raises o_enable_1, not o_enable_3.
REQ-038 A, B and opcode pulsed on three consecutive cycles -> enable strobes on three consecutive cycles with the matching o_alu_data.
